// File: rtl/ikaopm_slot_sequencer.sv
// Operator-datapath timing master: phi1 enable strobes, slot counter, zero-flush and halt parking.
// Optional IKAOPM_SEQ_ROUNDCNT_EN builds the completed-round counter behind o_ROUNDCNT.
module ikaopm_slot_sequencer #(
  parameter int DIV          = 4,
  parameter int NSLOTS       = 32,
  parameter int FLUSH_ROUNDS = 2,
  parameter int SLOT_W       = 5
) (
  input  logic              i_EMUCLK,
  input  logic              i_RST_n,
  input  logic              i_IC_n,
  input  logic              i_HALT_REQ,
  output logic              o_HALT_ACK,
  output logic              o_PCEN_n,
  output logic              o_NCEN_n,
  output logic [SLOT_W-1:0] o_SLOT,
  output logic              o_CYCLE0,
  output logic              o_CNTRRST,
  output logic              o_SRWR,
  output logic              o_FLUSH,
  output logic [15:0]       o_ROUNDCNT
);

  localparam int DIV_W = $clog2(DIV);
  localparam int FC_W  = $clog2(FLUSH_ROUNDS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST     = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF_PRE = DIV_W'(DIV / 2 - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST    = SLOT_W'(NSLOTS - 1);
  localparam logic [FC_W-1:0]   FLUSH_LAST   = FC_W'(FLUSH_ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_RUN,
    ST_HALTING,
    ST_HALTED
  } state_t;

  state_t            state, state_nx;
  logic [DIV_W-1:0]  div, div_nx;
  logic [SLOT_W-1:0] slot_nx;
  logic [FC_W-1:0]   flushcnt, flushcnt_nx;
  logic              advance;
  logic              wrap;

  // The divider only runs while the gate is open; strobes are registered from the
  // divider transition so a restart from div==0 never produces an immediate pulse.
  always_comb begin
    state_nx    = state;
    div_nx      = div;
    slot_nx     = o_SLOT;
    flushcnt_nx = flushcnt;
    advance     = 1'b0;
    wrap        = 1'b0;

    if (!i_IC_n) begin
      state_nx    = ST_FLUSH;
      div_nx      = '0;
      slot_nx     = '0;
      flushcnt_nx = '0;
    end else begin
      wrap    = !o_PCEN_n && (o_SLOT == SLOT_LAST);
      advance = (state != ST_HALTED);
      if (!o_PCEN_n) begin
        slot_nx = wrap ? '0 : o_SLOT + SLOT_W'(1);
      end

      case (state)
        ST_FLUSH: begin
          if (wrap) begin
            flushcnt_nx = flushcnt + FC_W'(1);
            if (flushcnt == FLUSH_LAST) state_nx = ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_HALT_REQ) state_nx = ST_HALTING;
        end
        ST_HALTING: begin
          if (!i_HALT_REQ) begin
            state_nx = ST_RUN;
          end else if (wrap) begin
            state_nx = ST_HALTED;
            advance  = 1'b0;
          end
        end
        ST_HALTED: begin
          if (!i_HALT_REQ) state_nx = ST_RUN;
        end
        default: state_nx = ST_FLUSH;
      endcase

      div_nx = advance ? ((div == DIV_LAST) ? '0 : div + DIV_W'(1)) : '0;
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state      <= ST_FLUSH;
      div        <= '0;
      flushcnt   <= '0;
      o_SLOT     <= '0;
      o_PCEN_n   <= 1'b1;
      o_NCEN_n   <= 1'b1;
      o_CYCLE0   <= 1'b1;
      o_CNTRRST  <= 1'b0;
      o_SRWR     <= 1'b1;
      o_FLUSH    <= 1'b1;
      o_HALT_ACK <= 1'b0;
    end else begin
      state      <= state_nx;
      div        <= div_nx;
      flushcnt   <= flushcnt_nx;
      o_SLOT     <= slot_nx;
      o_PCEN_n   <= !(advance && (div == DIV_LAST));
      o_NCEN_n   <= !(advance && (div == DIV_HALF_PRE));
      o_CYCLE0   <= (slot_nx == '0);
      o_CNTRRST  <= (slot_nx == SLOT_LAST);
      o_SRWR     <= (state_nx != ST_HALTED);
      o_FLUSH    <= (state_nx == ST_FLUSH);
      o_HALT_ACK <= (state_nx == ST_HALTED);
    end
  end

`ifdef IKAOPM_SEQ_ROUNDCNT_EN
  logic [15:0] roundcnt;

  // Counts wraps taken while running, including the wrap that parks the pipeline.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      roundcnt <= '0;
    end else if (!i_IC_n) begin
      roundcnt <= '0;
    end else if (wrap && ((state == ST_RUN) || (state == ST_HALTING))) begin
      roundcnt <= roundcnt + 16'd1;
    end
  end

  assign o_ROUNDCNT = roundcnt;
`else
  assign o_ROUNDCNT = 16'd0;
`endif

endmodule
